// File: rtl/regfile_sb_if.sv
// Register-file port bundle: writeback, two read sources, decode reservation, status.
// The master modport drives the register file; the slave modport is the register file side.
interface regfile_sb_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
);
   logic              write_enable;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] read_addr_A;
   logic [ADDR_W-1:0] read_addr_B;
   logic              use_A;
   logic              use_B;
   logic              reserve_en;
   logic [ADDR_W-1:0] reserve_addr;
   logic [DATA_W-1:0] read_data_A;
   logic [DATA_W-1:0] read_data_B;
   logic              busy_A;
   logic              busy_B;
   logic              stall;
   logic              reserve_err;

   modport master (
      output write_enable, write_addr, write_data, read_addr_A, read_addr_B,
      output use_A, use_B, reserve_en, reserve_addr,
      input  read_data_A, read_data_B, busy_A, busy_B, stall, reserve_err
   );

   modport slave (
      input  write_enable, write_addr, write_data, read_addr_A, read_addr_B,
      input  use_A, use_B, reserve_en, reserve_addr,
      output read_data_A, read_data_B, busy_A, busy_B, stall, reserve_err
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass and a per-register busy scoreboard driving stall.
// Define REGFILE_SB_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_sb #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 3,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input logic         clk,
   input logic         nRESET,
   regfile_sb_if.slave bus
);
   localparam int unsigned NREG = 2 ** ADDR_W;

`ifdef REGFILE_SB_R0_ZERO_EN
   localparam bit R0Zero = 1'b1;
`else
   localparam bit R0Zero = 1'b0;
`endif

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic              err_q, err_d;

   logic wr_en, res_en;
   logic wr_hit_a, wr_hit_b, zero_a, zero_b;
   logic err_set;

   // With R0 hardwired, writes and reservations aimed at address 0 simply never happen.
   assign wr_en  = bus.write_enable & ~(R0Zero & (bus.write_addr == '0));
   assign res_en = bus.reserve_en & ~(R0Zero & (bus.reserve_addr == '0));

   assign wr_hit_a = wr_en & (bus.write_addr == bus.read_addr_A);
   assign wr_hit_b = wr_en & (bus.write_addr == bus.read_addr_B);
   assign zero_a   = R0Zero & (bus.read_addr_A == '0);
   assign zero_b   = R0Zero & (bus.read_addr_B == '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[bus.write_addr] = bus.write_data;
   end

   // Reserve outranks release: a new producer claims the register even as the old one retires.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (res_en && (bus.reserve_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (wr_en && (bus.write_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   assign err_set = res_en & busy_q[bus.reserve_addr] &
                    ~(wr_en & (bus.write_addr == bus.reserve_addr));
   assign err_d   = err_q | err_set;

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign bus.read_data_A = zero_a   ? '0             :
                            wr_hit_a ? bus.write_data : regs_q[bus.read_addr_A];
   assign bus.read_data_B = zero_b   ? '0             :
                            wr_hit_b ? bus.write_data : regs_q[bus.read_addr_B];

   // A value landing this cycle is bypassed, so it no longer counts as pending.
   assign bus.busy_A      = busy_q[bus.read_addr_A] & ~wr_hit_a;
   assign bus.busy_B      = busy_q[bus.read_addr_B] & ~wr_hit_b;
   assign bus.stall       = (bus.use_A & bus.busy_A) | (bus.use_B & bus.busy_B);
   assign bus.reserve_err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb: one vector per clock cycle, outputs checked
// before the rising edge, plus hand-written reset sequences.
module tb_regfile_sb;
   logic clk;
   logic nRESET;

   regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   regfile_sb #(.DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h0000)) dut (
      .clk    (clk),
      .nRESET (nRESET),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef REGFILE_SB_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [2:0]  ra, rb;
      logic        ua, ub, re;
      logic [2:0]  rsa;
      logic [15:0] xa, xb;
      logic        xba, xbb, xst, xerr;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(string name, logic we, logic [2:0] wa, logic [15:0] wd,
                               logic [2:0] ra, logic [2:0] rb, logic ua, logic ub,
                               logic re, logic [2:0] rsa, logic [15:0] xa, logic [15:0] xb,
                               logic xba, logic xbb, logic xst, logic xerr);
      vec_t v;
      v.name = name; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
      v.ua = ua; v.ub = ub; v.re = re; v.rsa = rsa; v.xa = xa; v.xb = xb;
      v.xba = xba; v.xbb = xbb; v.xst = xst; v.xerr = xerr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic ua,
                        input logic ub, input logic re, input logic [2:0] rsa);
      bus.write_enable = we;  bus.write_addr   = wa;  bus.write_data = wd;
      bus.read_addr_A  = ra;  bus.read_addr_B  = rb;
      bus.use_A        = ua;  bus.use_B        = ub;
      bus.reserve_en   = re;  bus.reserve_addr = rsa;
   endtask

   task automatic check_outs(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                             input logic xba, input logic xbb, input logic xst,
                             input logic xerr);
      chk({nm, " read_data_A"}, bus.read_data_A, xa);
      chk({nm, " read_data_B"}, bus.read_data_B, xb);
      chk({nm, " busy_A"},      16'(bus.busy_A), 16'(xba));
      chk({nm, " busy_B"},      16'(bus.busy_B), 16'(xbb));
      chk({nm, " stall"},       16'(bus.stall), 16'(xst));
      chk({nm, " reserve_err"}, 16'(bus.reserve_err), 16'(xerr));
   endtask

   logic [15:0] za;

   initial begin
      za = R0Z ? 16'h0000 : 16'hFFFF;
      //         name         we wa  wd       ra rb ua ub re rsa xa       xb    bA bB st er
      vecs.push_back(mk("wr5_byp",   1, 5, 16'h1234, 5, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("rd5",       0, 0, 16'h0000, 5, 5, 0, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, 0));
      vecs.push_back(mk("wr3_byp",   1, 3, 16'hBEEF, 3, 5, 0, 0, 0, 0, 16'hBEEF, 16'h1234, 0, 0, 0, 0));
      vecs.push_back(mk("rd3",       0, 0, 16'h0000, 3, 3, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0));
      vecs.push_back(mk("res2",      0, 0, 16'h0000, 2, 2, 0, 1, 1, 2, 16'h0000, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("busy2",     0, 0, 16'h0000, 2, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0));
      vecs.push_back(mk("rel2_byp",  1, 2, 16'h00AA, 2, 2, 0, 1, 0, 0, 16'h00AA, 16'h00AA, 0, 0, 0, 0));
      vecs.push_back(mk("after2",    0, 0, 16'h0000, 2, 2, 0, 1, 0, 0, 16'h00AA, 16'h00AA, 0, 0, 0, 0));
      vecs.push_back(mk("resrel4",   1, 4, 16'h5555, 4, 5, 1, 0, 1, 4, 16'h5555, 16'h1234, 0, 0, 0, 0));
      vecs.push_back(mk("busy4",     0, 0, 16'h0000, 4, 4, 1, 0, 0, 0, 16'h5555, 16'h5555, 1, 1, 1, 0));
      vecs.push_back(mk("resrel4b",  1, 4, 16'h6666, 4, 3, 1, 0, 1, 4, 16'h6666, 16'hBEEF, 0, 0, 0, 0));
      vecs.push_back(mk("busy4b",    0, 0, 16'h0000, 4, 3, 1, 0, 0, 0, 16'h6666, 16'hBEEF, 1, 0, 1, 0));
      vecs.push_back(mk("r0_wrres",  1, 0, 16'hFFFF, 0, 0, 1, 1, 1, 0, za, za, 0, 0, 0, 0));
      vecs.push_back(mk("r0_read",   0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, za, za, !R0Z, !R0Z, !R0Z, 0));
      vecs.push_back(mk("r0_clear",  1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("res6",      0, 0, 16'h0000, 6, 6, 0, 0, 1, 6, 16'h0000, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("res6_again",0, 0, 16'h0000, 6, 6, 0, 0, 1, 6, 16'h0000, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk("err_sticky",1, 6, 16'h7777, 6, 1, 0, 0, 0, 0, 16'h7777, 16'h0000, 0, 0, 0, 1));
      vecs.push_back(mk("err_hold",  0, 0, 16'h0000, 6, 0, 0, 0, 0, 0, 16'h7777, 16'h0000, 0, 0, 0, 1));

      nRESET = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      nRESET = 1'b1;

      // Reset state: every address reads zero on both ports, nothing busy.
      for (int a = 0; a < 8; a++) begin
         drive(0, 0, 0, 3'(a), 3'(7 - a), 1, 1, 0, 0);
         #1;
         check_outs($sformatf("reset_r%0d", a), 16'h0000, 16'h0000, 0, 0, 0, 0);
         @(negedge clk);
      end

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb,
               vecs[i].ua, vecs[i].ub, vecs[i].re, vecs[i].rsa);
         #1;
         check_outs(vecs[i].name, vecs[i].xa, vecs[i].xb, vecs[i].xba, vecs[i].xbb,
                    vecs[i].xst, vecs[i].xerr);
         @(negedge clk);
      end

      // Reset asserted mid-operation with a write and a reservation pending.
      drive(1, 5, 16'hABCD, 4, 6, 1, 0, 1, 3);
      nRESET = 1'b0;
      #1;
      chk("midrst read_data_A", bus.read_data_A, 16'h0000);
      chk("midrst read_data_B", bus.read_data_B, 16'h0000);
      chk("midrst busy_A",      16'(bus.busy_A), 16'h0000);
      chk("midrst stall",       16'(bus.stall), 16'h0000);
      chk("midrst reserve_err", 16'(bus.reserve_err), 16'h0000);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 5, 3, 1, 1, 0, 0);
      #1;
      chk("inrst write_blocked", bus.read_data_A, 16'h0000);
      @(negedge clk);
      nRESET = 1'b1;
      #1;
      check_outs("postrst", 16'h0000, 16'h0000, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
